// File: rtl/load_store_unit.sv
// Memory-stage load/store sequencer: one word-aligned req/ack cache transaction per
// instruction, stalling the pipeline until ack and returning aligned, extended load data.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_rdata,
  output logic        mem_err,
  output logic        c_req,
  output logic        c_we,
  output logic [31:0] c_addr,
  output logic [3:0]  c_be,
  output logic [31:0] c_wdata,
  input  logic [31:0] c_rdata,
  input  logic        c_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam bit          USE_TIMEOUT = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] LAST        = USE_TIMEOUT ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t      state, state_next;
  logic [31:0] cnt;
  logic        is_load;
  logic [2:0]  mask_q;
  logic [1:0]  off_q;
  logic        req_any;
  logic        legal;
  logic        timeout;
  logic [3:0]  be_st;
  logic [31:0] wdata_st;
  logic [31:0] lane;
  logic [31:0] ext;

  assign req_any = rd_en | wr_en;
  assign timeout = USE_TIMEOUT && (cnt == LAST);

  // Legal size code and natural alignment; unsigned sizes are load-only.
  always_comb begin
    legal = 1'b0;
    case (mask)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~addr[0];
      3'b010:         legal = (addr[1:0] == 2'b00);
      default:        legal = 1'b0;
    endcase
    if (wr_en && mask[2])
      legal = 1'b0;
  end

  always_comb begin
    be_st    = 4'b1111;
    wdata_st = wdata;
    case (mask[1:0])
      2'b00: begin
        be_st    = 4'b0001 << addr[1:0];
        wdata_st = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_st    = 4'b0011 << addr[1:0];
        wdata_st = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane = c_rdata >> {off_q, 3'b000};

  always_comb begin
    case (mask_q[1:0])
      2'b00:   ext = {{24{lane[7] & ~mask_q[2]}}, lane[7:0]};
      2'b01:   ext = {{16{lane[15] & ~mask_q[2]}}, lane[15:0]};
      default: ext = lane;
    endcase
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        stall = req_any;
        if (req_any)
          state_next = legal ? REQ : ERR;
      end
      REQ: begin
        stall = 1'b1;
        if (c_ack)
          state_next = DONE;
        else if (timeout)
          state_next = ERR;
      end
      // The instruction is still presented in DONE/ERR, so its enables are ignored.
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= 32'd0;
      is_load    <= 1'b0;
      mask_q     <= 3'd0;
      off_q      <= 2'd0;
      c_we       <= 1'b0;
      c_addr     <= 32'd0;
      c_be       <= 4'd0;
      c_wdata    <= 32'd0;
      load_rdata <= 32'd0;
    end else begin
      if (state == IDLE && req_any) begin
        is_load <= ~wr_en;
        mask_q  <= mask;
        off_q   <= addr[1:0];
        c_we    <= wr_en;
        c_addr  <= {addr[31:2], 2'b00};
        c_be    <= wr_en ? be_st : 4'b1111;
        c_wdata <= wr_en ? wdata_st : 32'd0;
      end
      if (state == REQ)
        cnt <= cnt + 32'd1;
      else
        cnt <= 32'd0;
      if (state == REQ && c_ack && is_load)
        load_rdata <= ext;
    end
  end

  assign c_req      = (state == REQ);
  assign load_valid = (state == DONE) && is_load;
  assign mem_err    = (state == ERR);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed transactions, a spec-level model of the
// expected per-cycle outputs, and literal checks on the listed scenarios.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en, wr_en;
  logic [2:0]  mask;
  logic [31:0] addr, wdata;
  logic        stall, load_valid, mem_err, c_req, c_we, c_ack;
  logic [31:0] load_rdata, c_addr, c_wdata, c_rdata;
  logic [3:0]  c_be;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .mask(mask),
    .addr(addr), .wdata(wdata), .stall(stall), .load_valid(load_valid),
    .load_rdata(load_rdata), .mem_err(mem_err), .c_req(c_req), .c_we(c_we),
    .c_addr(c_addr), .c_be(c_be), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ack(c_ack)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
  endtask

  // Model-driven expectations, refreshed each cycle by the stimulus.
  bit          check_en = 0;
  logic        e_stall = 0, e_creq = 0, e_lv = 0, e_err = 0, e_we = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_rdata = 0;
  logic [3:0]  e_be = 0;
  int          stall_cnt = 0, creq_cnt = 0, err_cnt = 0;

  always @(negedge clk) begin
    if (stall) stall_cnt++;
    if (c_req) creq_cnt++;
    if (mem_err) err_cnt++;
    if (check_en) begin
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("c_req", {31'd0, c_req}, {31'd0, e_creq});
      chk("load_valid", {31'd0, load_valid}, {31'd0, e_lv});
      chk("mem_err", {31'd0, mem_err}, {31'd0, e_err});
      chk("load_rdata", load_rdata, e_rdata);
      if (e_creq) begin
        chk("c_we", {31'd0, c_we}, {31'd0, e_we});
        chk("c_addr", c_addr, e_addr);
        chk("c_be", {28'd0, c_be}, {28'd0, e_be});
        if (e_we) chk("c_wdata", c_wdata, e_wdata);
      end
    end
  end

  function automatic int nbytes(input logic [2:0] m);
    case (m[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_legal(input bit wr, input logic [2:0] m, input logic [31:0] a);
    int off = int'(a[1:0]);
    if (m == 3'b011 || m == 3'b110 || m == 3'b111) return 0;
    if (wr && m >= 3'b100) return 0;
    return (off % nbytes(m)) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] m, input logic [31:0] a, input logic [31:0] w);
    int     n = nbytes(m);
    int     off = int'(a[1:0]);
    longint v;
    v = (longint'(w) >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
    if (m < 3'b100 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] m, input logic [31:0] a);
    int n = nbytes(m);
    int off = int'(a[1:0]);
    int b = ((1 << n) - 1) << off;
    return b[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] m, input logic [31:0] d);
    int n = nbytes(m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_be;
  logic        snap_we;

  task automatic set_quiet();
    e_stall = 0; e_creq = 0; e_lv = 0; e_err = 0;
  endtask

  // k = cycle (counted from the request cycle) on which c_ack is returned; 0 = never.
  task automatic run(input string name, input bit wr, input bit both, input logic [2:0] m,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] w, input int k);
    bit ok;
    int limit;
    @(posedge clk); #1;
    rd_en = !wr || both; wr_en = wr; mask = m; addr = a; wdata = d;
    ok = m_legal(wr, m, a);
    set_quiet(); e_stall = 1;
    if (!ok) begin
      @(posedge clk); #1;
      set_quiet(); e_err = 1;
    end else begin
      e_we = wr; e_addr = {a[31:2], 2'b00};
      e_be = wr ? m_be(m, a) : 4'hF;
      e_wdata = m_wdata(m, d);
      limit = (k == 0) ? 8 : k;
      for (int c = 1; c <= limit; c++) begin
        @(posedge clk); #1;
        e_stall = 1; e_creq = 1;
        c_ack = (c == k);
        c_rdata = (c == k) ? w : 32'hDEADBEEF;
        if (c == 1) begin
          @(negedge clk);
          snap_addr = c_addr; snap_be = c_be; snap_wdata = c_wdata; snap_we = c_we;
        end
      end
      @(posedge clk); #1;
      c_ack = 0;
      set_quiet();
      if (k == 0) e_err = 1;
      else if (!wr) begin
        e_lv = 1;
        e_rdata = m_load(m, a, w);
      end
    end
    @(posedge clk); #1;
    rd_en = 0; wr_en = 0;
    set_quiet();
    $display("txn %s wr=%0b mask=%03b addr=0x%08h legal=%0b ack_cycle=%0d load_rdata=0x%08h",
             name, wr, m, a, ok, k, load_rdata);
  endtask

  int s0, r0, e0;

  initial begin
    reset = 1; rd_en = 0; wr_en = 0; mask = 0; addr = 0; wdata = 0; c_rdata = 0; c_ack = 0;
    #12;
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst c_req", {31'd0, c_req}, 32'd0);
    chk("rst c_be", {28'd0, c_be}, 32'd0);
    chk("rst load_rdata", load_rdata, 32'd0);
    chk("rst c_addr", c_addr, 32'd0);
    chk("rst mem_err", {31'd0, mem_err}, 32'd0);
    @(negedge clk); reset = 0; check_en = 1;

    run("lb", 0, 0, 3'b000, 32'h103, 0, 32'h80FF1234, 1);
    chk("t1 lb", load_rdata, 32'hFFFFFF80);
    run("lbu", 0, 0, 3'b100, 32'h103, 0, 32'h80FF1234, 1);
    chk("t1 lbu", load_rdata, 32'h00000080);

    run("sh", 1, 0, 3'b001, 32'h102, 32'hABCD1234, 0, 2);
    chk("t2 c_addr", snap_addr, 32'h100);
    chk("t2 c_be", {28'd0, snap_be}, 32'hC);
    chk("t2 c_wdata", snap_wdata, 32'h12341234);
    chk("t2 c_we", {31'd0, snap_we}, 32'd1);
    chk("t2 rdata held", load_rdata, 32'h00000080);

    s0 = stall_cnt; r0 = creq_cnt; e0 = err_cnt;
    run("lw misaligned", 0, 0, 3'b010, 32'h101, 0, 0, 1);
    chk("t3 stall cycles", stall_cnt - s0, 1);
    chk("t3 c_req cycles", creq_cnt - r0, 0);
    chk("t3 err pulses", err_cnt - e0, 1);

    s0 = stall_cnt;
    run("lhu", 0, 0, 3'b101, 32'h200, 0, 32'h0000F00D, 4);
    chk("t4 stall cycles", stall_cnt - s0, 5);
    chk("t4 lhu", load_rdata, 32'h0000F00D);

    r0 = creq_cnt; e0 = err_cnt;
    run("lw timeout", 0, 0, 3'b010, 32'h300, 0, 0, 0);
    chk("t5 c_req cycles", creq_cnt - r0, 8);
    chk("t5 err pulses", err_cnt - e0, 1);

    run("sb", 1, 0, 3'b000, 32'h101, 32'h00000055, 0, 1);
    chk("sb c_be", {28'd0, snap_be}, 32'h2);
    run("lh", 0, 0, 3'b001, 32'h102, 0, 32'h80011234, 2);
    chk("lh", load_rdata, 32'hFFFF8001);
    run("ld mask011", 0, 0, 3'b011, 32'h0, 0, 0, 1);
    run("st mask100", 1, 0, 3'b100, 32'h0, 32'h1, 0, 1);
    run("rd+wr", 1, 1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h11111111, 1);
    chk("rd+wr c_we", {31'd0, snap_we}, 32'd1);
    run("lw", 0, 0, 3'b010, 32'h24, 0, 32'h89ABCDEF, 3);

    // A stray ack while idle must not start anything.
    @(posedge clk); #1; c_ack = 1; c_rdata = 32'h12345678;
    @(posedge clk); #1; c_ack = 0;
    @(posedge clk); #1;

    // Reset in the middle of a request.
    @(posedge clk); #1;
    rd_en = 1; mask = 3'b010; addr = 32'h80;
    set_quiet(); e_stall = 1;
    @(posedge clk); #1;
    e_creq = 1; e_we = 0; e_addr = 32'h80; e_be = 4'hF;
    @(posedge clk); #1;
    check_en = 0;
    #2; reset = 1; rd_en = 0;
    #1;
    chk("t6 c_req async", {31'd0, c_req}, 32'd0);
    chk("t6 stall async", {31'd0, stall}, 32'd0);
    chk("t6 load_rdata", load_rdata, 32'd0);
    @(negedge clk); reset = 0;
    set_quiet(); e_rdata = 0;
    @(posedge clk); #1; check_en = 1;
    run("sw", 1, 0, 3'b010, 32'h40, 32'h0BADBEEF, 0, 2);
    chk("t6 sw c_be", {28'd0, snap_be}, 32'hF);
    chk("t6 sw c_addr", snap_addr, 32'h40);
    @(posedge clk); #1;
    check_en = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
